// File: rtl/bsg_mul_iterative_arbiter.sv
// bsg_mul_iterative_arbiter
//
// Shares one iterative multiplier among num_req_p requesters. A round-robin
// grant picks one requester in idle. Its operands are registered and issued
// to the multiplier. The product is captured and then handed back to the
// owning requester only. One operation is in flight at a time.
//
// Ports
//   clk_i, reset_n_i        : clock, asynchronous active-low reset
//   v_i / ready_o           : per-requester request valid / accept (one-hot)
//   opA_i, opB_i, signed_i  : packed per-requester operands and signed flag
//   v_o / yumi_i            : per-requester result valid / consume (one-hot)
//   result_o                : registered product, shared by all requesters
//   mul_v_o / mul_ready_i   : issue handshake toward the multiplier
//   mul_opA_o, mul_opB_o,
//   mul_signed_o            : registered operands toward the multiplier
//   mul_v_i / mul_yumi_o    : result handshake from the multiplier
//   mul_result_i            : multiplier product
//   done_cnt_o              : results consumed by requesters (wraps)

module bsg_mul_iterative_arbiter #(
    parameter int num_req_p   = 4,
    parameter int width_p     = 64,
    parameter int cnt_width_p = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [num_req_p-1:0]         v_i,
    output logic [num_req_p-1:0]         ready_o,
    input  logic [num_req_p*width_p-1:0] opA_i,
    input  logic [num_req_p*width_p-1:0] opB_i,
    input  logic [num_req_p-1:0]         signed_i,
    output logic [num_req_p-1:0]         v_o,
    output logic [2*width_p-1:0]         result_o,
    input  logic [num_req_p-1:0]         yumi_i,
    output logic                         mul_v_o,
    input  logic                         mul_ready_i,
    output logic [width_p-1:0]           mul_opA_o,
    output logic [width_p-1:0]           mul_opB_o,
    output logic                         mul_signed_o,
    input  logic                         mul_v_i,
    input  logic [2*width_p-1:0]         mul_result_i,
    output logic                         mul_yumi_o,
    output logic [cnt_width_p-1:0]       done_cnt_o
);

    localparam int ptr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic [1:0] {eIdle, eIssue, eWait, eReturn} state_e;

    state_e                 state_q;
    logic [ptr_w_lp-1:0]    rr_ptr_q;
    logic [ptr_w_lp-1:0]    owner_q;
    logic [width_p-1:0]     opA_q;
    logic [width_p-1:0]     opB_q;
    logic                   signed_q;
    logic [2*width_p-1:0]   result_q;
    logic [cnt_width_p-1:0] done_cnt_q;

    logic [num_req_p-1:0]   grant_oh;
    logic [ptr_w_lp-1:0]    grant_idx;
    logic                   grant_any;
    logic [width_p-1:0]     opA_sel;
    logic [width_p-1:0]     opB_sel;
    logic                   signed_sel;
    logic [ptr_w_lp-1:0]    next_ptr;

    // Round-robin search: walk num_req_p positions starting at rr_ptr_q,
    // wrapping at num_req_p (modulo handles non-power-of-two counts).
    always_comb begin
        int                  pos;
        logic [ptr_w_lp-1:0] idx;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int k = 0; k < num_req_p; k++) begin
            pos = (int'(rr_ptr_q) + k) % num_req_p;
            idx = ptr_w_lp'(pos);
            if (!grant_any && v_i[idx]) begin
                grant_any     = 1'b1;
                grant_idx     = idx;
                grant_oh[idx] = 1'b1;
            end
        end
    end

    // Operand slice of the winning requester.
    always_comb begin
        opA_sel    = '0;
        opB_sel    = '0;
        signed_sel = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            if (grant_oh[k]) begin
                opA_sel    = opA_i[k*width_p +: width_p];
                opB_sel    = opB_i[k*width_p +: width_p];
                signed_sel = signed_i[k];
            end
        end
    end

    assign next_ptr = (owner_q == ptr_w_lp'(num_req_p - 1)) ? '0 : owner_q + 1'b1;

    // ready_o is combinational from v_i; it is forced low while reset is held
    // so that every output reads zero during reset.
    assign ready_o = (state_q == eIdle && reset_n_i) ? grant_oh : '0;

    always_comb begin
        v_o          = '0;
        v_o[owner_q] = (state_q == eReturn);
    end

    assign result_o     = result_q;
    assign mul_v_o      = (state_q == eIssue);
    assign mul_opA_o    = opA_q;
    assign mul_opB_o    = opB_q;
    assign mul_signed_o = signed_q;
    assign mul_yumi_o   = (state_q == eWait) && mul_v_i;
    assign done_cnt_o   = done_cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= eIdle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            signed_q   <= 1'b0;
            result_q   <= '0;
            done_cnt_q <= '0;
        end else begin
            unique case (state_q)
                eIdle: begin
                    if (grant_any) begin
                        opA_q    <= opA_sel;
                        opB_q    <= opB_sel;
                        signed_q <= signed_sel;
                        owner_q  <= grant_idx;
                        state_q  <= eIssue;
                    end
                end
                eIssue: begin
                    if (mul_ready_i) state_q <= eWait;
                end
                eWait: begin
                    if (mul_v_i) begin
                        result_q <= mul_result_i;
                        state_q  <= eReturn;
                    end
                end
                eReturn: begin
                    // Only the owner's yumi counts; other bits are ignored.
                    if (yumi_i[owner_q]) begin
                        rr_ptr_q   <= next_ptr;
                        done_cnt_q <= done_cnt_q + 1'b1;
                        state_q    <= eIdle;
                    end
                end
                default: state_q <= eIdle;
            endcase
        end
    end

    // A multiplier result before the operation was issued and accepted is a
    // protocol error; it is not consumed or captured in those states.
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(mul_v_i && (state_q == eIdle || state_q == eIssue)))
        else $error("mul_v_i asserted before issue completed");

endmodule

// File: tb/tb_bsg_mul_iterative_arbiter.sv
module tb_bsg_mul_iterative_arbiter;

    localparam int NR = 4;
    localparam int W  = 64;
    localparam int CW = 2;
    localparam int M  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n = 1'b0;
    logic [NR-1:0]     v_i = '0, ready_o, signed_i = '0, v_o, yumi_i = '0;
    logic [NR*W-1:0]   opA_i = '0, opB_i = '0;
    logic [2*W-1:0]    result_o, mul_result_i;
    logic              mul_v_o, mul_ready_i, mul_signed_o, mul_v_i, mul_yumi_o;
    logic [W-1:0]      mul_opA_o, mul_opB_o;
    logic [CW-1:0]     done_cnt_o;

    bsg_mul_iterative_arbiter #(.num_req_p(NR), .width_p(W), .cnt_width_p(CW)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .v_i(v_i), .ready_o(ready_o), .opA_i(opA_i), .opB_i(opB_i), .signed_i(signed_i),
        .v_o(v_o), .result_o(result_o), .yumi_i(yumi_i),
        .mul_v_o(mul_v_o), .mul_ready_i(mul_ready_i), .mul_opA_o(mul_opA_o),
        .mul_opB_o(mul_opB_o), .mul_signed_o(mul_signed_o), .mul_v_i(mul_v_i),
        .mul_result_i(mul_result_i), .mul_yumi_o(mul_yumi_o), .done_cnt_o(done_cnt_o)
    );

    // Iterative multiplier stand-in: M cycles from accept to result valid.
    logic           hold_ready = 1'b0;
    logic           mbusy = 1'b0;
    int             mcnt = 0;
    logic [2*W-1:0] mprod = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
            mprod <= '0;
        end else if (!mbusy) begin
            if (mul_v_o && mul_ready_i) begin
                mbusy <= 1'b1;
                mcnt  <= M - 1;
                mprod <= mul_signed_o ?
                    {{W{mul_opA_o[W-1]}}, mul_opA_o} * {{W{mul_opB_o[W-1]}}, mul_opB_o} :
                    {{W{1'b0}}, mul_opA_o} * {{W{1'b0}}, mul_opB_o};
            end
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end else if (mul_yumi_o) begin
            mbusy <= 1'b0;
        end
    end

    assign mul_ready_i  = !mbusy && !hold_ready;
    assign mul_v_i      = mbusy && (mcnt == 0);
    assign mul_result_i = mprod;

    // Reference model state
    logic [W-1:0] opa [NR];
    logic [W-1:0] opb [NR];
    logic         sg  [NR];
    int m_ptr = 0;
    int m_cnt = 0;
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        logic signed [2*W-1:0] sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    function automatic int model_winner(input logic [NR-1:0] mask);
        for (int k = 0; k < NR; k++)
            if (mask[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        return 0;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            opA_i[i*W +: W] = opa[i];
            opB_i[i*W +: W] = opb[i];
            signed_i[i]     = sg[i];
        end
    endtask

    // Precondition: called just after a negedge (inputs set here are seen by
    // the next posedge). Returns at the same phase.
    task automatic do_op(input logic [NR-1:0] vmask, input logic [2*W-1:0] exp,
                         input int rstall, input int ystall);
        int w, c;
        bit got;
        logic [NR-1:0] woh, wrong;
        w = model_winner(vmask);
        woh = '0;
        woh[w] = 1'b1;
        wrong = {woh[NR-2:0], woh[NR-1]};
        drive_ops();
        v_i = vmask;
        #1;
        chk("grant", ready_o, woh);
        c = 0;
        got = 0;
        while (!got && c < 60) begin
            @(negedge clk);
            c++;
            if (c == 1) v_i = v_i & ~woh;
            hold_ready = (c <= rstall);
            #1;
            if (v_o != '0) got = 1;
            else begin
                chk("ready_busy", ready_o, 0);
                chk("mul_yumi", mul_yumi_o, mul_v_i);
                if (c <= rstall + 1) begin
                    chk("mul_v", mul_v_o, 1);
                    chk("mul_opA", mul_opA_o, opa[w]);
                    chk("mul_opB", mul_opB_o, opb[w]);
                    chk("mul_signed", mul_signed_o, sg[w]);
                end else begin
                    chk("mul_v_off", mul_v_o, 0);
                end
            end
        end
        hold_ready = 1'b0;
        if (!got) begin
            chk("timeout", 0, 1);
            return;
        end
        chk("latency", c, 2 + M + rstall);
        chk("v_o", v_o, woh);
        chk("result", result_o, exp);
        for (int j = 0; j <= ystall; j++) begin
            yumi_i = (j == ystall) ? woh : wrong;
            @(negedge clk);
            yumi_i = '0;
            #1;
            if (j < ystall) begin
                chk("v_o_hold", v_o, woh);
                chk("result_hold", result_o, exp);
                chk("ready_hold", ready_o, 0);
            end
        end
        m_cnt++;
        m_ptr = (w + 1) % NR;
        chk("v_o_clear", v_o, 0);
        chk("done_cnt", done_cnt_o, m_cnt % (1 << CW));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        v_i = '0;
        yumi_i = '0;
        hold_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
        #1;
    endtask

    typedef struct {
        int             req;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] mask;
        int w;
        tbl[0] = '{2, 64'd7, 64'd6, 1'b0, 128'd42};
        tbl[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1,
                   {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1}};
        tbl[2] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1};
        tbl[3] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 128'h1_FFFF_FFFF_FFFF_FFFE};
        tbl[4] = '{2, 64'h8000_0000_0000_0000, 64'd2, 1'b1,
                   {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}};
        tbl[5] = '{1, 64'h8000_0000_0000_0000, 64'd2, 1'b0, 128'h1_0000_0000_0000_0000};
        tbl[6] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                   128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        for (int i = 0; i < NR; i++) begin
            opa[i] = '0;
            opb[i] = '0;
            sg[i]  = 1'b0;
        end

        // Reset state, with requests pending during reset
        reset_n = 1'b0;
        v_i = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", ready_o, 0);
        chk("rst_v_o", v_o, 0);
        chk("rst_mul_v", mul_v_o, 0);
        chk("rst_mul_yumi", mul_yumi_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_done", done_cnt_o, 0);
        chk("rst_opA", mul_opA_o, 0);
        v_i = '0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Table of single-requester operations
        for (int t = 0; t < 7; t++) begin
            opa[tbl[t].req] = tbl[t].a;
            opb[tbl[t].req] = tbl[t].b;
            sg[tbl[t].req]  = tbl[t].s;
            do_op(4'b0001 << tbl[t].req, tbl[t].exp, 0, 0);
        end

        // Round-robin with all requesters continuously valid
        do_reset();
        for (int i = 0; i < NR; i++) begin
            opa[i] = 64'(i + 3);
            opb[i] = 64'(10 * (i + 1));
            sg[i]  = 1'b0;
        end
        for (int t = 0; t < 5; t++) begin
            w = model_winner(4'b1111);
            chk("rr_order", w, t % NR);
            do_op(4'b1111, ref_mul(opa[w], opb[w], sg[w]), 0, 0);
        end
        v_i = '0;

        // Backpressure: 3 stalled issue cycles, 4 cycles of wrong-owner yumi,
        // other requesters waiting throughout
        opa[1] = 64'hFFFF_FFFF_FFFF_FFF0;
        opb[1] = 64'd3;
        sg[1]  = 1'b1;
        while (model_winner(4'b1011) != 1) begin
            w = model_winner(4'b1111);
            do_op(4'b0001 << w, ref_mul(opa[w], opb[w], sg[w]), 0, 0);
        end
        do_op(4'b1011, ref_mul(opa[1], opb[1], sg[1]), 3, 4);
        v_i = '0;

        // Reset during eWait, then a clean operation from requester 0
        opa[3] = 64'd9;
        opb[3] = 64'd9;
        sg[3]  = 1'b0;
        drive_ops();
        v_i = 4'b1000;
        @(negedge clk);
        v_i = 4'b0000;
        @(negedge clk);
        #1;
        chk("pre_rst_wait", mul_v_o, 0);
        @(negedge clk);
        v_i = 4'b0001;
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", ready_o, 0);
        chk("midrst_v_o", v_o, 0);
        chk("midrst_mul_v", mul_v_o, 0);
        chk("midrst_result", result_o, 0);
        chk("midrst_done", done_cnt_o, 0);
        chk("midrst_opA", mul_opA_o, 0);
        v_i = '0;
        @(negedge clk);
        reset_n = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
        #1;
        opa[0] = 64'd11;
        opb[0] = 64'd13;
        sg[0]  = 1'b0;
        do_op(4'b0001, 128'd143, 0, 0);

        // Counter wrap: 5 completions since reset on a 2-bit counter
        for (int t = 1; t < 5; t++)
            do_op(4'b0001 << t[1:0], ref_mul(opa[t % NR], opb[t % NR], sg[t % NR]), 1, 0);
        chk("cnt_wrap", done_cnt_o, 1);

        // Randomized traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NR; i++) begin
                opa[i] = {$urandom, $urandom};
                opb[i] = {$urandom, $urandom};
                sg[i]  = 1'($urandom_range(0, 1));
            end
            mask = 4'($urandom_range(1, 15));
            w = model_winner(mask);
            do_op(mask, ref_mul(opa[w], opb[w], sg[w]),
                  $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) v_i = '0;
        end
        v_i = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
